riscv_dmem_arbiter: RTL and testbench

RISCV_DMEM_ARBITER -- requirements
Module: riscv_dmem_arbiter

---
 rtl/riscv_dmem_arbiter_pkg.sv | 20 ++
 rtl/riscv_rr_arb2.sv | 34 +++
 rtl/riscv_dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_arbiter_pkg.sv
// ============================================================================
// riscv_defines : shared data-memory arbiter constants and XLEN
// Rev 1.0
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`default_nettype none

package riscv_defines;
  localparam int XLEN = `XLEN;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_OWN0 = 2'd1;
  localparam logic [1:0] c_OWN1 = 2'd2;

  localparam int c_LOCK_MAX_DEF = 16;
endpackage

`default_nettype wire

// File: rtl/riscv_rr_arb2.sv
// ============================================================================
// riscv_rr_arb2 : two-way round-robin / fixed-priority pick
// Rev 1.0
// ============================================================================
`default_nettype none

module riscv_rr_arb2
  import riscv_defines::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_gnt0,
  output logic o_gnt1
);

  logic w_pick1;

  // i_last is the previous winner; on contention the other side wins
  always_comb begin
    w_pick1 = i_req1;
    if (i_req0 && i_req1) begin
      w_pick1 = (FIXED_PRIO != 0) ? 1'b0 : ~i_last;
    end
  end

  assign o_gnt0 = i_req0 & ~w_pick1;
  assign o_gnt1 = i_req1 & w_pick1;

endmodule

`default_nettype wire

// File: rtl/riscv_dmem_arbiter.sv
// ============================================================================
// riscv_dmem_arbiter : two-master arbiter with lock FSM in front of riscv_dmem
// Rev 1.0
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`default_nettype none

module riscv_dmem_arbiter
  import riscv_defines::*;
#(
  parameter int LOCK_MAX   = c_LOCK_MAX_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_m0_req,
  input  logic              i_m0_wr_en,
  input  logic [`XLEN-1:0]  i_m0_addr,
  input  logic [3:0]        i_m0_byte_sel,
  input  logic [`XLEN-1:0]  i_m0_wr_data,
  input  logic              i_m0_lock,
  output logic              o_m0_gnt,
  output logic              o_m0_rvalid,
  output logic [`XLEN-1:0]  o_m0_rd_data,
  input  logic              i_m1_req,
  input  logic              i_m1_wr_en,
  input  logic [`XLEN-1:0]  i_m1_addr,
  input  logic [3:0]        i_m1_byte_sel,
  input  logic [`XLEN-1:0]  i_m1_wr_data,
  input  logic              i_m1_lock,
  output logic              o_m1_gnt,
  output logic              o_m1_rvalid,
  output logic [`XLEN-1:0]  o_m1_rd_data,
  output logic              o_mem_wr_en,
  output logic [`XLEN-1:0]  o_mem_addr,
  output logic [3:0]        o_mem_byte_sel,
  output logic [`XLEN-1:0]  o_mem_wr_data,
  input  logic [`XLEN-1:0]  i_mem_rd_data
);

  localparam int c_CW = $clog2(LOCK_MAX + 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [c_CW-1:0]  r_cnt;
  logic [c_CW-1:0]  w_cnt_nxt;
  logic [c_CW-1:0]  w_cnt_inc;
  logic             r_last;
  logic             r_rd_pend;
  logic             r_rd_owner;
  logic [`XLEN-1:0] r_addr;
  logic [`XLEN-1:0] r_wdata;
  logic [3:0]       r_bsel;

  logic             w_own0, w_own1;
  logic             w_req0, w_req1;
  logic             w_gnt0, w_gnt1, w_gnt;
  logic             w_cont;
  logic             w_wr, w_lock;
  logic [`XLEN-1:0] w_addr, w_wdata;
  logic [3:0]       w_bsel;
  logic             w_rv0, w_rv1;

  // An owner that drops req releases ownership at once, so the other side may win that cycle
  assign w_own0 = (r_state == c_OWN0) && i_m0_req;
  assign w_own1 = (r_state == c_OWN1) && i_m1_req;
  assign w_req0 = i_rstn & i_m0_req & ~w_own1;
  assign w_req1 = i_rstn & i_m1_req & ~w_own0;

  riscv_rr_arb2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_arb (
    .i_req0 (w_req0),
    .i_req1 (w_req1),
    .i_last (r_last),
    .o_gnt0 (w_gnt0),
    .o_gnt1 (w_gnt1)
  );

  assign w_gnt   = w_gnt0 | w_gnt1;
  assign w_wr    = w_gnt1 ? i_m1_wr_en    : i_m0_wr_en;
  assign w_lock  = w_gnt1 ? i_m1_lock     : i_m0_lock;
  assign w_addr  = w_gnt1 ? i_m1_addr     : i_m0_addr;
  assign w_bsel  = w_gnt1 ? i_m1_byte_sel : i_m0_byte_sel;
  assign w_wdata = w_gnt1 ? i_m1_wr_data  : i_m0_wr_data;

  assign w_cont    = (w_gnt0 && (r_state == c_OWN0)) || (w_gnt1 && (r_state == c_OWN1));
  assign w_cnt_inc = (w_cont ? r_cnt : {c_CW{1'b0}}) + c_CW'(1);

  always_comb begin
    w_state_nxt = c_IDLE;
    w_cnt_nxt   = '0;
    if (w_gnt && w_lock && (w_cnt_inc != c_CW'(LOCK_MAX))) begin
      w_state_nxt = w_gnt1 ? c_OWN1 : c_OWN0;
      w_cnt_nxt   = w_cnt_inc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_last     <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
      r_addr     <= '0;
      r_bsel     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_pend  <= w_gnt & ~w_wr;
      r_rd_owner <= w_gnt1;
      if (w_gnt) begin
        r_last  <= w_gnt1;
        r_addr  <= w_addr;
        r_bsel  <= w_bsel;
        r_wdata <= w_wdata;
      end
    end
  end

  // Reset gates the return path so a read granted just before reset never completes
  assign w_rv0 = i_rstn & r_rd_pend & ~r_rd_owner;
  assign w_rv1 = i_rstn & r_rd_pend & r_rd_owner;

  assign o_m0_gnt       = w_gnt0;
  assign o_m1_gnt       = w_gnt1;
  assign o_m0_rvalid    = w_rv0;
  assign o_m1_rvalid    = w_rv1;
  assign o_m0_rd_data   = w_rv0 ? i_mem_rd_data : '0;
  assign o_m1_rd_data   = w_rv1 ? i_mem_rd_data : '0;
  assign o_mem_wr_en    = w_gnt & w_wr;
  assign o_mem_addr     = !i_rstn ? '0 : (w_gnt ? w_addr  : r_addr);
  assign o_mem_byte_sel = !i_rstn ? '0 : (w_gnt ? w_bsel  : r_bsel);
  assign o_mem_wr_data  = !i_rstn ? '0 : (w_gnt ? w_wdata : r_wdata);

endmodule

`default_nettype wire

// File: tb/tb_riscv_dmem_arbiter.sv
// ============================================================================
// tb_riscv_dmem_arbiter : scoreboard bench with behavioural arbitration model
// Rev 1.0
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`default_nettype none

module tb_riscv_dmem_arbiter;
  localparam int LMAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [1:0]  req, wr, lock;
  logic [31:0] addr  [2];
  logic [3:0]  bsel  [2];
  logic [31:0] wdata [2];
  logic [31:0] mem_rd;

  logic        g0, g1, rv0, rv1, mwr;
  logic [31:0] rd0, rd1, maddr, mwdata;
  logic [3:0]  mbsel;

  logic        fg0, fg1, frv0, frv1, fmwr;
  logic [31:0] frd0, frd1, fmaddr, fmwdata;
  logic [3:0]  fmbsel;

  riscv_dmem_arbiter #(.LOCK_MAX(LMAX), .FIXED_PRIO(0)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(req[0]), .i_m0_wr_en(wr[0]), .i_m0_addr(addr[0]), .i_m0_byte_sel(bsel[0]),
    .i_m0_wr_data(wdata[0]), .i_m0_lock(lock[0]),
    .o_m0_gnt(g0), .o_m0_rvalid(rv0), .o_m0_rd_data(rd0),
    .i_m1_req(req[1]), .i_m1_wr_en(wr[1]), .i_m1_addr(addr[1]), .i_m1_byte_sel(bsel[1]),
    .i_m1_wr_data(wdata[1]), .i_m1_lock(lock[1]),
    .o_m1_gnt(g1), .o_m1_rvalid(rv1), .o_m1_rd_data(rd1),
    .o_mem_wr_en(mwr), .o_mem_addr(maddr), .o_mem_byte_sel(mbsel), .o_mem_wr_data(mwdata),
    .i_mem_rd_data(mem_rd)
  );

  riscv_dmem_arbiter #(.LOCK_MAX(LMAX), .FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .i_rstn(rstn),
    .i_m0_req(req[0]), .i_m0_wr_en(wr[0]), .i_m0_addr(addr[0]), .i_m0_byte_sel(bsel[0]),
    .i_m0_wr_data(wdata[0]), .i_m0_lock(lock[0]),
    .o_m0_gnt(fg0), .o_m0_rvalid(frv0), .o_m0_rd_data(frd0),
    .i_m1_req(req[1]), .i_m1_wr_en(wr[1]), .i_m1_addr(addr[1]), .i_m1_byte_sel(bsel[1]),
    .i_m1_wr_data(wdata[1]), .i_m1_lock(lock[1]),
    .o_m1_gnt(fg1), .o_m1_rvalid(frv1), .o_m1_rd_data(frd1),
    .o_mem_wr_en(fmwr), .o_mem_addr(fmaddr), .o_mem_byte_sel(fmbsel), .o_mem_wr_data(fmwdata),
    .i_mem_rd_data(mem_rd)
  );

  typedef struct {
    int cyc; bit rst; bit g0; bit g1; bit wr;
    logic [31:0] a; logic [3:0] b; logic [31:0] d;
  } exp_t;
  typedef struct { int cyc; int who; logic [31:0] d; } rv_t;
  typedef struct { int cyc; bit g0; bit g1; } fp_t;

  exp_t expq[$];
  rv_t  rvq[$];
  fp_t  fpq[$];

  int n_chk = 0, n_fail = 0, cyc = 0;
  int m_owner = -1, m_last = 1, m_run = 0, m_win = -1;
  logic [31:0] m_a = '0, m_d = '0;
  logic [3:0]  m_b = '0;

  // Memory contents are a fixed function of the address, so read data identifies the address
  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5a5a_1234;
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    mem_rd <= memf(maddr);
  end

  // Reference: owner keeps the bus while requesting (up to LMAX grants), otherwise
  // a lone requester wins and contention goes to whoever did not win last.
  task automatic model_cycle();
    exp_t e;
    int   w;
    w     = -1;
    e.cyc = cyc;
    e.rst = !rstn;
    if (!rstn) begin
      m_owner = -1; m_last = 1; m_run = 0;
      m_a = '0; m_b = '0; m_d = '0;
      while (rvq.size() > 0 && rvq[rvq.size()-1].cyc == cyc) rvq.delete(rvq.size()-1);
    end else begin
      if (m_owner >= 0 && req[m_owner]) w = m_owner;
      else if (req[0] && req[1])        w = 1 - m_last;
      else if (req[0])                  w = 0;
      else if (req[1])                  w = 1;
      if (w >= 0) begin
        m_run  = (w == m_owner) ? m_run + 1 : 1;
        m_last = w;
        m_a = addr[w]; m_b = bsel[w]; m_d = wdata[w];
        if (!wr[w]) rvq.push_back('{cyc + 1, w, memf(addr[w])});
        if (lock[w] && m_run < LMAX) m_owner = w;
        else begin m_owner = -1; m_run = 0; end
      end else begin
        m_owner = -1; m_run = 0;
      end
    end
    e.g0 = (w == 0);
    e.g1 = (w == 1);
    e.wr = (w >= 0) ? wr[w] : 1'b0;
    e.a = m_a; e.b = m_b; e.d = m_d;
    m_win = w;
    expq.push_back(e);
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic setr(input int m, input bit r, input bit w, input logic [31:0] a, input bit lk);
    req[m] = r; wr[m] = w; addr[m] = a; bsel[m] = 4'hF;
    wdata[m] = a ^ 32'hdead_beef; lock[m] = lk;
  endtask

  task automatic new_req(input int m);
    req[m]   = 1'b1;
    wr[m]    = 1'($urandom % 2);
    addr[m]  = $urandom & 32'hFFFF_FFFC;
    bsel[m]  = 4'($urandom % 16);
    wdata[m] = $urandom;
    lock[m]  = (($urandom % 3) == 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    rv_t  r;
    fp_t  f;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      n_chk++;
      if (e.cyc != cyc || g0 !== e.g0 || g1 !== e.g1) begin
        n_fail++;
        $display("FAIL gnt cyc=%0d: got g0=%b g1=%b (rec cyc %0d), expected g0=%b g1=%b",
                 cyc, g0, g1, e.cyc, e.g0, e.g1);
      end
      n_chk++;
      if ({mwr, maddr, mbsel, mwdata} !== {e.wr, e.a, e.b, e.d}) begin
        n_fail++;
        $display("FAIL mem cyc=%0d: got wr=%b a=%h b=%h d=%h, expected wr=%b a=%h b=%h d=%h",
                 cyc, mwr, maddr, mbsel, mwdata, e.wr, e.a, e.b, e.d);
      end
      if (e.rst) begin
        n_chk++;
        if ({rv0, rv1, rd0, rd1} !== 66'd0) begin
          n_fail++;
          $display("FAIL rst_out cyc=%0d: got rv0=%b rv1=%b rd0=%h rd1=%h, expected all 0",
                   cyc, rv0, rv1, rd0, rd1);
        end
      end
    end
    if (rv0 === 1'b1 || rv1 === 1'b1) begin
      n_chk++;
      if (rvq.size() == 0) begin
        n_fail++;
        $display("FAIL rvalid_unexp cyc=%0d: got rv0=%b rv1=%b, expected none", cyc, rv0, rv1);
      end else begin
        r = rvq.pop_front();
        if (r.cyc != cyc || rv0 !== (r.who == 0) || rv1 !== (r.who == 1) ||
            ((r.who == 0) ? rd0 : rd1) !== r.d) begin
          n_fail++;
          $display("FAIL rvalid cyc=%0d: got rv0=%b rv1=%b rd0=%h rd1=%h, expected m%0d data=%h at cyc %0d",
                   cyc, rv0, rv1, rd0, rd1, r.who, r.d, r.cyc);
        end
      end
    end else if (rvq.size() > 0 && rvq[0].cyc <= cyc) begin
      r = rvq.pop_front();
      n_chk++;
      n_fail++;
      $display("FAIL rvalid_missing cyc=%0d: got rv0=%b rv1=%b, expected m%0d data=%h",
               cyc, rv0, rv1, r.who, r.d);
    end
    if (fpq.size() > 0 && fpq[0].cyc == cyc) begin
      f = fpq.pop_front();
      n_chk++;
      if (fg0 !== f.g0 || fg1 !== f.g1) begin
        n_fail++;
        $display("FAIL fixed_prio cyc=%0d: got g0=%b g1=%b, expected g0=%b g1=%b",
                 cyc, fg0, fg1, f.g0, f.g1);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    for (int m = 0; m < 2; m++) setr(m, 1'b0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    tick();
    tick();
    rstn = 1'b1;

    // Two writes from reset: m0 first, then m1
    setr(0, 1'b1, 1'b1, 32'h10, 1'b0);
    setr(1, 1'b1, 1'b1, 32'h20, 1'b0);
    tick();
    setr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    setr(1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // Back-to-back reads from different masters
    setr(0, 1'b1, 1'b0, 32'h40, 1'b0);
    tick();
    setr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    setr(1, 1'b1, 1'b0, 32'h44, 1'b0);
    tick();
    setr(1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // m1 locked with continuous requests, m0 waiting
    setr(1, 1'b1, 1'b0, 32'h100, 1'b1);
    tick();
    setr(0, 1'b1, 1'b1, 32'h200, 1'b0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (m_win == 0) setr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    end
    setr(1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Locked owner drops req for one cycle while the other requests
    setr(0, 1'b1, 1'b1, 32'h300, 1'b1);
    tick();
    setr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    setr(1, 1'b1, 1'b1, 32'h304, 1'b0);
    tick();
    setr(1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // Reset immediately after a read grant
    setr(0, 1'b1, 1'b0, 32'h400, 1'b1);
    tick();
    setr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Fixed-priority instance: both requesting for 5 cycles
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    setr(0, 1'b1, 1'b1, 32'h500, 1'b0);
    setr(1, 1'b1, 1'b1, 32'h504, 1'b0);
    for (int k = 0; k < 5; k++) begin
      fpq.push_back('{cyc, 1'b1, 1'b0});
      tick();
    end
    setr(0, 1'b0, 1'b0, 32'h0, 1'b0);
    setr(1, 1'b0, 1'b0, 32'h0, 1'b0);
    tick();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rstn = (($urandom % 150) != 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        if (!(req[m] && m_win != m)) begin
          if (($urandom % 10) < 7) new_req(m);
          else req[m] = 1'b0;
        end
      end
    end

    rstn = 1'b1;
    req  = 2'b00;
    tick();
    tick();
    tick();
    n_chk++;
    if (expq.size() != 0 || rvq.size() != 0 || fpq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got expq=%0d rvq=%0d fpq=%0d outstanding, expected 0",
               expq.size(), rvq.size(), fpq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
